dac_spi_salida: RTL and testbench

DAC_SPI_SALIDA -- requirements
Module: dac_spi_salida

---
 rtl/dac_spi_salida.sv | 139 +++++++++++++
 tb/tb_dac_spi_salida.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_salida.sv
// Output stage: truncates/saturates the accumulated Q16.32 product to a
// Q8.16 sample, keeps a one-deep pending buffer, and ships each sample to a
// 12-bit offset-binary DAC over a 16-bit SPI frame (mode 2: sclk idles high,
// data changes on rising edges, DAC samples on falling edges).
module dac_spi_salida #(
  parameter int N       = 25,
  parameter int F       = 16,
  parameter int CLK_DIV = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [2*N-1:0] Acumulado,
  input  logic           Signal,
  output logic [N-1:0]   Truncado,
  output logic           busy,
  output logic           overrun,
  output logic           frame_done,
  output logic           sync_n,
  output logic           sclk,
  output logic           sdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int             DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

  logic [1:0]     state;
  logic [DW-1:0]  div_cnt;
  logic [3:0]     bit_cnt;
  logic [15:0]    shreg;
  logic           pend_valid;
  logic [11:0]    pend_code;

  logic [N-1:0]   sample;
  logic [11:0]    sample_code;
  logic [N-F:0]   guard;
  logic           sat;
  logic           unused_frac;

  // Guard bits above the window must all match the sign, else the value
  // does not fit in Q8.16 and is clamped to the nearest extreme.
  assign guard       = Acumulado[2*N-1:N+F-1];
  assign sat         = !((&guard) || !(|guard));
  assign unused_frac = ^Acumulado[F-1:0];

  // Saturating truncation and offset-binary DAC code of the incoming value
  always_comb begin
    sample = Acumulado[N+F-1:F];
    if (sat)
      sample = Acumulado[2*N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    sample_code = {~sample[N-1], sample[N-2:N-12]};
  end

  // Sample register plus one-deep pending buffer; latest sample wins.
  // A strobe during LOAD lands after the buffer has been consumed, so it
  // is not an overwrite.
  always_ff @(posedge clk) begin
    if (reset) begin
      Truncado   <= '0;
      pend_valid <= 1'b0;
      pend_code  <= '0;
      overrun    <= 1'b0;
    end else begin
      if (Signal) begin
        Truncado   <= sample;
        pend_code  <= sample_code;
        pend_valid <= 1'b1;
        if (pend_valid && state != LOAD) overrun <= 1'b1;
      end else if (state == LOAD) begin
        pend_valid <= 1'b0;
      end
    end
  end

  // Frame FSM; all serial outputs are registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      sync_n     <= 1'b1;
      sclk       <= 1'b1;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pend_valid) begin
            state   <= LOAD;
            sync_n  <= 1'b0;
            busy    <= 1'b1;
            bit_cnt <= 4'd15;
            div_cnt <= '0;
          end
        end
        LOAD: begin
          // frame MSB is a zero pad bit, so sdata is already correct here
          shreg   <= {4'b0000, pend_code};
          div_cnt <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (sclk) begin
              sclk <= 1'b0;
            end else if (bit_cnt == 4'd0) begin
              // closing rising edge after the last low half-period
              state      <= DONE;
              sclk       <= 1'b1;
              sync_n     <= 1'b1;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              shreg      <= '0;
            end else begin
              sclk    <= 1'b1;
              shreg   <= {shreg[14:0], 1'b0};
              bit_cnt <= bit_cnt - 4'd1;
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign sdata = shreg[15];

endmodule

// File: tb/tb_dac_spi_salida.sv
// Directed bench for dac_spi_salida (default parameters, CLK_DIV=4).
module tb_dac_spi_salida;

  logic        clk;
  logic        reset;
  logic [49:0] Acumulado;
  logic        Signal;
  logic [24:0] Truncado;
  logic        busy, overrun, frame_done, sync_n, sclk, sdata;

  int total = 0;
  int bad   = 0;

  dac_spi_salida dut (
    .clk(clk), .reset(reset), .Acumulado(Acumulado), .Signal(Signal),
    .Truncado(Truncado), .busy(busy), .overrun(overrun),
    .frame_done(frame_done), .sync_n(sync_n), .sclk(sclk), .sdata(sdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [49:0] a);
    Acumulado = a;
    Signal    = 1'b1;
    @(negedge clk);
    Signal    = 1'b0;
  endtask

  task automatic wait_busy(input string tag);
    int n = 0;
    while (!busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_start"}, {31'd0, busy}, 32'd1);
  endtask

  // Called on the first busy cycle (LOAD). Optionally strobes b and c
  // mid-frame. Checks length, sclk falling count, data stability at each
  // falling edge, sync_n low time and the captured bits.
  task automatic do_frame(input string tag, input logic [15:0] exp_bits,
                          input bit inj2, input logic [49:0] b, input logic [49:0] c,
                          output logic ov_mid);
    logic [15:0] bits = '0;
    int len = 1, falls = 0, stab_bad = 0, low_cnt = 0;
    logic ps, pd;
    ov_mid  = 1'b0;
    low_cnt = (sync_n == 1'b0) ? 1 : 0;
    ps = sclk;
    pd = sdata;
    while (!frame_done && len < 400) begin
      @(negedge clk);
      Signal = 1'b0;
      len++;
      if (!sync_n) low_cnt++;
      if (ps && !sclk) begin
        falls++;
        bits = {bits[14:0], sdata};
        if (sdata !== pd) stab_bad++;
      end
      ps = sclk;
      pd = sdata;
      if (inj2 && len == 6)  begin Acumulado = b; Signal = 1'b1; end
      if (inj2 && len == 10) ov_mid = overrun;
      if (inj2 && len == 12) begin Acumulado = c; Signal = 1'b1; end
    end
    chk({tag, "_bits"},   {16'd0, bits}, {16'd0, exp_bits});
    chk({tag, "_len"},    len,      32'd130);
    chk({tag, "_falls"},  falls,    32'd16);
    chk({tag, "_stable"}, stab_bad, 32'd0);
    chk({tag, "_synclow"}, low_cnt, 32'd129);
    chk({tag, "_done_io"}, {29'd0, sync_n, sclk, busy}, 32'b110);
  endtask

  task automatic idle_for(input int cycles, output int busy_cnt, output int done_cnt);
    busy_cnt = 0;
    done_cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (frame_done) done_cnt++;
    end
  endtask

  initial begin
    logic        ovm;
    logic [49:0] one, m_one, big, m_big, zero;
    int          bc, dc, n, falls;
    logic        ps;

    one   = 50'd1 << 32;
    m_one = -one;
    big   = 50'd1 << 45;
    m_big = -big;
    zero  = '0;

    reset = 1'b1; Signal = 1'b0; Acumulado = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_trunc", {7'd0, Truncado}, 32'd0);
    chk("rst_flags", {28'd0, busy, overrun, frame_done, sdata}, 32'd0);
    chk("rst_lines", {30'd0, sync_n, sclk}, 32'b11);

    // 1.0 -> 0x0010000, frame 0x0808
    pulse(one);
    chk("one_trunc", {7'd0, Truncado}, 32'h0010000);
    wait_busy("one");
    do_frame("one", 16'h0808, 1'b0, zero, zero, ovm);

    pulse(big);
    chk("pos_sat_trunc", {7'd0, Truncado}, 32'h0FFFFFF);
    wait_busy("pos_sat");
    do_frame("pos_sat", 16'h0FFF, 1'b0, zero, zero, ovm);

    pulse(m_big);
    chk("neg_sat_trunc", {7'd0, Truncado}, 32'h1000000);
    wait_busy("neg_sat");
    do_frame("neg_sat", 16'h0000, 1'b0, zero, zero, ovm);

    pulse(zero);
    chk("zero_trunc", {7'd0, Truncado}, 32'h0);
    wait_busy("zero");
    do_frame("zero", 16'h0800, 1'b0, zero, zero, ovm);

    pulse(m_one);
    chk("mone_trunc", {7'd0, Truncado}, 32'h1FF0000);
    wait_busy("mone");
    do_frame("mone", 16'h07F8, 1'b0, zero, zero, ovm);
    @(negedge clk);
    chk("idle_lines", {29'd0, sync_n, sclk, sdata}, 32'b110);

    // strobe in the LOAD cycle becomes the next frame, no overrun
    pulse(one);
    wait_busy("ld1");
    Acumulado = zero; Signal = 1'b1;
    do_frame("ld1", 16'h0808, 1'b0, zero, zero, ovm);
    wait_busy("ld2");
    do_frame("ld2", 16'h0800, 1'b0, zero, zero, ovm);
    chk("ld_overrun", {31'd0, overrun}, 32'd0);
    idle_for(40, bc, dc);
    chk("ld_no_extra", bc, 32'd0);

    // three strobes in one frame: latest wins, overrun set, two frames
    pulse(one);
    wait_busy("ov1");
    do_frame("ov1", 16'h0808, 1'b1, zero, m_one, ovm);
    chk("ov_mid", {31'd0, ovm}, 32'd0);
    chk("ov_set", {31'd0, overrun}, 32'd1);
    wait_busy("ov2");
    do_frame("ov2", 16'h07F8, 1'b0, zero, zero, ovm);
    idle_for(300, bc, dc);
    chk("ov_no_extra", bc + dc, 32'd0);
    chk("ov_sticky", {31'd0, overrun}, 32'd1);

    // truncation edge cases around the saturation boundary
    pulse(50'd1 << 40);
    chk("b40_sat", {7'd0, Truncado}, 32'h0FFFFFF);
    pulse((50'd1 << 40) - (50'd1 << 17));
    chk("b40_fit", {7'd0, Truncado}, 32'h0FFFFFE);
    pulse(-(50'd1 << 40));
    chk("mb40_fit", {7'd0, Truncado}, 32'h1000000);
    pulse((50'd1 << 39) + (50'd1 << 16));
    chk("b39_fit", {7'd0, Truncado}, 32'h0800001);

    // reset with Signal held: strobe ignored, overrun cleared
    reset = 1'b1; Acumulado = one; Signal = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0; Signal = 1'b0;
    chk("rst2_trunc", {7'd0, Truncado}, 32'd0);
    chk("rst2_ovr", {31'd0, overrun}, 32'd0);
    idle_for(30, bc, dc);
    chk("rst2_no_frame", bc + dc, 32'd0);

    // reset while bit 7 is on the wire
    pulse(one);
    wait_busy("mid");
    n = 0; falls = 0; ps = sclk;
    while (falls < 8 && n < 200) begin
      @(negedge clk);
      n++;
      if (ps && !sclk) falls++;
      ps = sclk;
    end
    chk("mid_reached", falls, 32'd8);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_lines", {28'd0, sync_n, sclk, busy, sdata}, 32'b1100);
    chk("mid_done", {31'd0, frame_done}, 32'd0);
    reset = 1'b0;
    idle_for(300, bc, dc);
    chk("mid_no_frame", bc + dc, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
